// File: rtl/ift_mem_pkg.sv
// Shared types for the taint-tracking multi-port SRAM: port limits, taint-merge constants
// and the response pipeline entry carried from grant to rvalid.
package ift_mem_pkg;

  localparam int MaxPorts = 4;
  localparam int PortIdW  = $clog2(MaxPorts);
  localparam int MaxWidth = 1024;

  localparam logic [7:0] TaintByteAll   = 8'hFF;
  localparam logic [7:0] TaintByteClean = 8'h00;

  typedef struct packed {
    logic                valid;
    logic                valid_taint;
    logic [PortIdW-1:0]  port;
    logic                err;
    logic                err_taint;
    logic [MaxWidth-1:0] data;
    logic [MaxWidth-1:0] data_taint;
  } rsp_pipe_t;

  // A tainted strobe poisons the whole byte, since which bytes changed is itself secret.
  function automatic logic [7:0] merge_taint_byte(input logic [7:0] old_t,
                                                  input logic [7:0] wdat_t,
                                                  input logic       strb,
                                                  input logic       strb_t);
    if (strb_t) return TaintByteAll;
    if (strb)   return wdat_t;
    return old_t;
  endfunction

endpackage

// File: rtl/ift_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant, search starts after the last winner.
// Zero latency; no grant while reset is asserted.
module ift_rr_arb import ift_mem_pkg::*; #(
  parameter int NumPorts = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumPorts-1:0] req_i,
  output logic [NumPorts-1:0] gnt_o
);

  logic [PortIdW-1:0] ptr_q, ptr_d;
  logic [PortIdW-1:0] win;
  logic               hit;
  int                 j;

  always_comb begin
    gnt_o = '0;
    win   = '0;
    hit   = 1'b0;
    j     = 0;
    if (!rst_i) begin
      for (int k = 0; k < NumPorts; k++) begin
        j = (int'(ptr_q) + k) % NumPorts;
        if (!hit && req_i[j]) begin
          hit      = 1'b1;
          gnt_o[j] = 1'b1;
          win      = PortIdW'(j);
        end
      end
    end
    ptr_d = hit ? PortIdW'((int'(win) + 1) % NumPorts) : ptr_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ift_sram_mem_mp.sv
// Multi-port SRAM with a bit-level taint shadow; one access per cycle, round-robin arbitrated.
// Response after ReadLatency cycles, fully pipelined, no backpressure (ports retry until granted).
module ift_sram_mem_mp import ift_mem_pkg::*; #(
  parameter int          NumPorts           = 2,
  parameter int          Width              = 64,
  parameter int          Depth              = 1 << 17,
  parameter int          ReadLatency        = 1,
  parameter logic [63:0] RelocateRequestUp  = 64'h0,
  parameter bit          TaintAddrPropagate = 1'b1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumPorts-1:0]                 req_i,
  input  logic [NumPorts-1:0]                 req_i_taint,
  input  logic [NumPorts-1:0]                 we_i,
  input  logic [NumPorts-1:0]                 we_i_taint,
  input  logic [NumPorts-1:0][63:0]           addr_i,
  input  logic [NumPorts-1:0][63:0]           addr_i_taint,
  input  logic [NumPorts-1:0][Width-1:0]      wdata_i,
  input  logic [NumPorts-1:0][Width-1:0]      wdata_i_taint,
  input  logic [NumPorts-1:0][Width/8-1:0]    strb_i,
  input  logic [NumPorts-1:0][Width/8-1:0]    strb_i_taint,
  output logic [NumPorts-1:0]                 gnt_o,
  output logic [NumPorts-1:0]                 gnt_o_taint,
  output logic [NumPorts-1:0]                 rvalid_o,
  output logic [NumPorts-1:0]                 rvalid_o_taint,
  output logic [NumPorts-1:0][Width-1:0]      rdata_o,
  output logic [NumPorts-1:0][Width-1:0]      rdata_o_taint,
  output logic [NumPorts-1:0]                 err_o,
  output logic [NumPorts-1:0]                 err_o_taint,
  output logic                                taint_addr_write_o
);

  localparam int Bytes = Width / 8;
  localparam int OffW  = $clog2(Bytes);
  localparam int AW    = (Depth > 1) ? $clog2(Depth) : 1;

  logic [NumPorts-1:0] gnt;
  logic                gvld;
  logic [PortIdW-1:0]  gidx;
  logic                sel_we, sel_req_t;
  logic [63:0]         sel_addr, sel_addr_t, idx;
  logic [Width-1:0]    sel_wdata, sel_wdata_t;
  logic [Bytes-1:0]    sel_strb, sel_strb_t;
  logic                in_range, addr_tainted, wr_en;
  logic [AW-1:0]       widx;
  logic [Width-1:0]    cur_dat, cur_tnt, wr_dat_d, wr_tnt_d, rd_dat, rd_tnt;
  rsp_pipe_t           ent, last;
  rsp_pipe_t           pipe_q [ReadLatency];
  rsp_pipe_t           pipe_d [ReadLatency];
  logic                taint_addr_write_q, taint_addr_write_d;
  logic                any_req_t;
  logic                unused_sink;

  logic [Width-1:0] mem_q     [Depth];
  logic [Width-1:0] mem_tnt_q [Depth];

  ift_rr_arb #(.NumPorts(NumPorts)) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (req_i),
    .gnt_o (gnt)
  );

  always_comb begin
    gidx        = '0;
    sel_we      = 1'b0;
    sel_req_t   = 1'b0;
    sel_addr    = '0;
    sel_addr_t  = '0;
    sel_wdata   = '0;
    sel_wdata_t = '0;
    sel_strb    = '0;
    sel_strb_t  = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (gnt[p]) begin
        gidx        = PortIdW'(p);
        sel_we      = we_i[p];
        sel_req_t   = req_i_taint[p];
        sel_addr    = addr_i[p];
        sel_addr_t  = addr_i_taint[p];
        sel_wdata   = wdata_i[p];
        sel_wdata_t = wdata_i_taint[p];
        sel_strb    = strb_i[p];
        sel_strb_t  = strb_i_taint[p];
      end
    end
  end

  // Addresses below the relocation base wrap to a huge index and land out of range.
  assign gvld         = |gnt;
  assign idx          = (sel_addr - RelocateRequestUp) >> OffW;
  assign in_range     = idx < 64'(Depth);
  assign widx         = idx[AW-1:0];
  assign addr_tainted = |sel_addr_t;
  assign wr_en        = gvld && sel_we && in_range;
  assign cur_dat      = mem_q[widx];
  assign cur_tnt      = mem_tnt_q[widx];

  always_comb begin
    wr_dat_d = cur_dat;
    wr_tnt_d = cur_tnt;
    for (int b = 0; b < Bytes; b++) begin
      if (sel_strb[b]) wr_dat_d[b*8 +: 8] = sel_wdata[b*8 +: 8];
      wr_tnt_d[b*8 +: 8] = merge_taint_byte(cur_tnt[b*8 +: 8], sel_wdata_t[b*8 +: 8],
                                            sel_strb[b], sel_strb_t[b]);
    end
  end

  always_comb begin
    rd_dat = '0;
    rd_tnt = '0;
    if (!sel_we) begin
      if (in_range) begin
        rd_dat = cur_dat;
        rd_tnt = cur_tnt;
      end
      if (TaintAddrPropagate && addr_tainted) rd_tnt = '1;
    end
  end

  always_comb begin
    ent = '0;
    if (gvld) begin
      ent.valid                 = 1'b1;
      ent.valid_taint           = sel_req_t;
      ent.port                  = gidx;
      ent.err                   = !in_range;
      ent.err_taint             = sel_req_t;
      ent.data[Width-1:0]       = rd_dat;
      ent.data_taint[Width-1:0] = rd_tnt;
    end
    pipe_d[0] = ent;
    for (int i = 1; i < ReadLatency; i++) pipe_d[i] = pipe_q[i-1];
    taint_addr_write_d = taint_addr_write_q || (gvld && sel_we && addr_tainted);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ReadLatency; i++) pipe_q[i] <= '0;
      taint_addr_write_q <= 1'b0;
    end else begin
      for (int i = 0; i < ReadLatency; i++) pipe_q[i] <= pipe_d[i];
      taint_addr_write_q <= taint_addr_write_d;
    end
  end

  // Storage arrays carry no reset; contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[widx]     <= wr_dat_d;
      mem_tnt_q[widx] <= wr_tnt_d;
    end
  end

  assign last      = pipe_q[ReadLatency-1];
  assign any_req_t = |(req_i & req_i_taint);

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      rvalid_o[p]       = last.valid && (last.port == PortIdW'(p));
      rvalid_o_taint[p] = rvalid_o[p] && last.valid_taint;
      err_o[p]          = rvalid_o[p] && last.err;
      err_o_taint[p]    = rvalid_o[p] && last.err_taint;
      rdata_o[p]        = rvalid_o[p] ? last.data[Width-1:0] : '0;
      rdata_o_taint[p]  = rvalid_o[p] ? last.data_taint[Width-1:0] : '0;
      gnt_o_taint[p]    = !rst_i && req_i[p] && any_req_t;
    end
  end

  assign gnt_o              = gnt;
  assign taint_addr_write_o = taint_addr_write_q;
  assign unused_sink        = ^{we_i_taint, last};

endmodule

// File: tb/tb_ift_sram_mem_mp.sv
// Directed bench for ift_sram_mem_mp: arbitration, byte strobes, taint merge and propagation,
// out-of-range handling, read-after-write and reset abort, against hand-computed values.
module tb_ift_sram_mem_mp;

  localparam int NP    = 2;
  localparam int W     = 64;
  localparam int DEPTH = 1024;
  localparam int RL    = 2;

  logic                  clk, rst;
  logic [NP-1:0]         req, req_t, we, we_t;
  logic [NP-1:0][63:0]   addr, addr_t, wdata, wdata_t;
  logic [NP-1:0][7:0]    strb, strb_t;
  logic [NP-1:0]         gnt, gnt_t, rvalid, rvalid_t, err, err_t;
  logic [NP-1:0][63:0]   rdata, rdata_t;
  logic                  taw;

  int n_checks = 0;
  int n_errs   = 0;

  logic [63:0] r_dat, r_tnt;
  logic        r_err;

  ift_sram_mem_mp #(
    .NumPorts(NP), .Width(W), .Depth(DEPTH), .ReadLatency(RL),
    .RelocateRequestUp(64'h0), .TaintAddrPropagate(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_i(req), .req_i_taint(req_t), .we_i(we), .we_i_taint(we_t),
    .addr_i(addr), .addr_i_taint(addr_t), .wdata_i(wdata), .wdata_i_taint(wdata_t),
    .strb_i(strb), .strb_i_taint(strb_t),
    .gnt_o(gnt), .gnt_o_taint(gnt_t), .rvalid_o(rvalid), .rvalid_o_taint(rvalid_t),
    .rdata_o(rdata), .rdata_o_taint(rdata_t), .err_o(err), .err_o_taint(err_t),
    .taint_addr_write_o(taw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    req = '0; req_t = '0; we = '0; we_t = '0;
    addr = '0; addr_t = '0; wdata = '0; wdata_t = '0;
    strb = '0; strb_t = '0;
  endtask

  // Single request on port p; checks grant, exact response latency and response taints.
  task automatic issue(input int p, input logic w, input logic [63:0] a, input logic [63:0] d,
                       input logic [7:0] s, input logic [63:0] dt, input logic [7:0] st,
                       input logic [63:0] at, input logic rt);
    logic [1:0] oh;
    oh = 2'(1 << p);
    @(negedge clk);
    idle();
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d; strb[p] = s;
    wdata_t[p] = dt; strb_t[p] = st; addr_t[p] = at; req_t[p] = rt;
    #1;
    chk("gnt", 64'(gnt), 64'(oh));
    chk("gnt_taint", 64'(gnt_t), rt ? 64'(oh) : 64'h0);
    @(posedge clk);
    #1 idle();
    for (int k = 1; k < RL; k++) begin
      @(negedge clk);
      chk("rvalid_early", 64'(rvalid), 64'h0);
      @(posedge clk);
    end
    @(negedge clk);
    chk("rvalid", 64'(rvalid), 64'(oh));
    chk("rvalid_taint", 64'(rvalid_t), rt ? 64'(oh) : 64'h0);
    chk("err_taint", 64'(err_t), rt ? 64'(oh) : 64'h0);
    r_dat = rdata[p];
    r_tnt = rdata_t[p];
    r_err = err[p];
  endtask

  initial begin
    idle();
    rst = 1'b1;
    req = 2'b11; req_t = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_gnt_taint", 64'(gnt_t), 64'h0);
    chk("rst_rvalid", 64'(rvalid), 64'h0);
    chk("rst_rdata0", rdata[0], 64'h0);
    chk("rst_taw", 64'(taw), 64'h0);
    @(negedge clk);
    idle();
    rst = 1'b0;

    // Both ports request for 4 cycles: grants alternate, responses stream back-to-back.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req  = (c < 4) ? 2'b11 : 2'b00;
      addr[0] = 64'h100; addr[1] = 64'h108;
      #1;
      chk("rr_gnt", 64'(gnt), (c < 4) ? 64'(1 << (c % 2)) : 64'h0);
      chk("rr_rvalid", 64'(rvalid), (c >= RL) ? 64'(1 << ((c - RL) % 2)) : 64'h0);
    end
    idle();
    repeat (RL + 1) @(negedge clk);

    issue(0, 1'b1, 64'h0, 64'h1122334455667788, 8'hFF, 64'h0, 8'h00, 64'h0, 1'b0);
    chk("wr_rdata_zero", r_dat, 64'h0);
    chk("wr_err", 64'(r_err), 64'h0);
    issue(0, 1'b0, 64'h0, 64'h0, 8'h00, 64'h0, 8'h00, 64'h0, 1'b0);
    chk("rd_data", r_dat, 64'h1122334455667788);
    chk("rd_taint", r_tnt, 64'h0);

    // Byte-strobe and taint merge.
    issue(1, 1'b1, 64'h10, 64'h0123456789ABCDEF, 8'hFF, 64'h0, 8'h00, 64'h0, 1'b0);
    issue(1, 1'b1, 64'h10, 64'hFFFFFFFFFFFF5A5A, 8'h03, 64'h00FF, 8'h04, 64'h0, 1'b0);
    issue(1, 1'b0, 64'h10, 64'h0, 8'h00, 64'h0, 8'h00, 64'h0, 1'b0);
    chk("strb_data", r_dat, 64'h0123456789AB5A5A);
    chk("strb_taint", r_tnt, 64'h0000000000FF00FF);

    // Address taint on read and on write.
    issue(0, 1'b0, 64'h0, 64'h0, 8'h00, 64'h0, 8'h00, 64'h1, 1'b0);
    chk("addr_taint_rd_data", r_dat, 64'h1122334455667788);
    chk("addr_taint_rd_taint", r_tnt, 64'hFFFFFFFFFFFFFFFF);
    chk("taw_before", 64'(taw), 64'h0);
    issue(1, 1'b1, 64'h18, 64'h5555, 8'hFF, 64'h0, 8'h00, 64'h1, 1'b1);
    chk("taw_set", 64'(taw), 64'h1);
    issue(0, 1'b0, 64'h18, 64'h0, 8'h00, 64'h0, 8'h00, 64'h0, 1'b0);
    chk("taw_sticky", 64'(taw), 64'h1);

    // gnt taint is the OR over all requesting ports.
    @(negedge clk);
    idle();
    req = 2'b11; req_t = 2'b01;
    #1;
    chk("gnt_taint_or", 64'(gnt_t), 64'h3);
    chk("gnt_onehot", 64'($countones(gnt)), 64'h1);
    @(negedge clk);
    idle();
    repeat (RL + 1) @(negedge clk);

    // Read the cycle after a write to the same word.
    @(negedge clk);
    idle();
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 64'h20; wdata[0] = 64'hCAFEF00DDEADBEEF;
    strb[0] = 8'hFF; wdata_t[0] = 64'h0F;
    @(negedge clk);
    we[0] = 1'b0; wdata[0] = '0; wdata_t[0] = '0; strb[0] = '0;
    #1;
    chk("raw_gnt", 64'(gnt), 64'h1);
    @(posedge clk);
    #1 idle();
    repeat (RL - 1) @(posedge clk);
    @(negedge clk);
    chk("raw_rvalid", 64'(rvalid), 64'h1);
    chk("raw_data", rdata[0], 64'hCAFEF00DDEADBEEF);
    chk("raw_taint", rdata_t[0], 64'h0F);

    // Out of range.
    issue(0, 1'b0, 64'(DEPTH * 8), 64'h0, 8'h00, 64'h0, 8'h00, 64'h0, 1'b0);
    chk("oor_rd_err", 64'(r_err), 64'h1);
    chk("oor_rd_data", r_dat, 64'h0);
    issue(1, 1'b1, 64'(DEPTH * 8), 64'hDEADDEADDEADDEAD, 8'hFF, 64'h0, 8'h00, 64'h0, 1'b0);
    chk("oor_wr_err", 64'(r_err), 64'h1);
    issue(0, 1'b0, 64'h0, 64'h0, 8'h00, 64'h0, 8'h00, 64'h0, 1'b0);
    chk("oor_mem_intact", r_dat, 64'h1122334455667788);

    // Reset one cycle after a read grant aborts it and rewinds the pointer.
    @(negedge clk);
    idle();
    req[0] = 1'b1; addr[0] = 64'h0;
    #1;
    chk("abort_gnt", 64'(gnt), 64'h1);
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    rst = 1'b1;
    req = 2'b11; req_t = 2'b11;
    #1;
    chk("abort_rst_gnt", 64'(gnt), 64'h0);
    chk("abort_rst_taw", 64'(taw), 64'h0);
    chk("abort_rst_rvalid", 64'(rvalid), 64'h0);
    @(negedge clk);
    idle();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_no_rvalid", 64'(rvalid), 64'h0);
    end
    @(negedge clk);
    req = 2'b11;
    #1;
    chk("ptr_reset_gnt", 64'(gnt), 64'h1);
    chk("taw_after_rst", 64'(taw), 64'h0);
    @(negedge clk);
    idle();
    repeat (RL + 1) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/ift_sram_mem_mp.md
IFT_SRAM_MEM_MP -- requirements
Module: ift_sram_mem_mp

Interface
REQ-001 SHALL have parameter NumPorts, default 2, number of requestor ports (1..4).
REQ-002 SHALL have parameter Width, default 64, data width in bits (multiple of 8).
REQ-003 SHALL have parameter Depth, default 1<<17, number of Width-bit words.
REQ-004 SHALL have parameter ReadLatency, default 1, cycles from grant to rvalid (1..3).
REQ-005 SHALL have parameter RelocateRequestUp, default 64'h0, byte base address subtracted from every request.
REQ-006 SHALL have parameter TaintAddrPropagate, default 1, enables address-taint propagation to read data.
REQ-007 SHALL have clk_i  in  1  sole clock, rising edge.
REQ-008 SHALL have rst_i  in  1  reset, asynchronous, active-high.
REQ-009 SHALL have per-port inputs, each packed [NumPorts-1:0][...]:
- req_i  1
- we_i  1
- addr_i  64  byte address
- wdata_i  Width
- strb_i  Width/8
REQ-010 SHALL have per-port outputs:
- gnt_o  1
- rvalid_o  1
- rdata_o  Width
- err_o  1
REQ-011 SHALL have a _taint companion of identical width for every data-bearing port above; clk_i and rst_i have none.
REQ-012 SHALL have taint_addr_write_o  out  1  sticky flag: a write with tainted address occurred.

Function
REQ-013 SHALL grant at most one port per cycle, combinationally, round-robin: the search starts at the port after the last granted one; the pointer advances only on a grant.
REQ-014 SHALL perform the granted access in the grant cycle; word index = (addr - RelocateRequestUp) >> log2(Width/8).
REQ-015 SHALL, on a granted write, update each byte whose strb bit is 1; other bytes are unchanged.
REQ-016 SHALL return rvalid_o, rdata_o and err_o on the granted port exactly ReadLatency cycles after the grant, for reads and writes alike; write rdata = 0.
REQ-017 SHALL treat an index >= Depth as out of range: the write is dropped, the read returns 0, and err_o=1 with that rvalid.
REQ-018 SHALL keep the taint shadow memory at one taint bit per data bit.
REQ-019 SHALL, on a write, set stored taint = wdata_taint for bytes with strb=1 and strb_taint=0; bytes with strb_taint=1 become all-ones taint; other bytes keep their taint.
REQ-020 SHALL return rdata_o_taint = stored taint of the read word; if TaintAddrPropagate and any addr_i_taint bit is set, it SHALL be all ones.
REQ-021 SHALL set gnt_o_taint of every requesting port to the OR of req_i_taint over all requesting ports.
REQ-022 SHALL delay rvalid_o_taint and err_o_taint from req_i_taint of the granted port through the same ReadLatency pipeline.
REQ-023 SHALL set taint_addr_write_o on a granted write with nonzero addr_i_taint; it clears only on reset.
REQ-024 SHALL make a read issued the cycle after a write to the same word return the new data and taint (no hazard).
REQ-025 SHALL keep the response pipeline fully pipelined: one response per cycle, no backpressure.

Reset
REQ-026 SHALL, while rst_i=1, drive the following to 0:
- all gnt, rvalid, err, rdata outputs and their taints
- taint_addr_write_o
- the pipeline valid bits
- the round-robin pointer (port 0 highest priority)
REQ-027 SHALL abort any in-flight response when reset is asserted mid-operation: no rvalid after release.
REQ-028 SHALL leave data and taint memory contents unreset; simulation SHALL zero-initialise the taint shadow.

Structure
REQ-029 SHALL place MaxPorts, the taint-merge rule constants and the response-pipeline struct (valid, port id, err, data, taints) in package ift_mem_pkg.
REQ-030 SHALL implement the arbiter as sub-module ift_rr_arb (NumPorts parameter; req vector in, one-hot gnt out, pointer register inside).

Verification
REQ-031 Port0 writes 0x1122334455667788 with strb 0xFF to 0x0, then reads 0x0 -> rvalid after ReadLatency, rdata 0x1122334455667788, taint 0.
REQ-032 Ports 0 and 1 request continuously for 4 cycles -> grants alternate 0,1,0,1; exactly one gnt per cycle.
REQ-033 Write with wdata_taint 0x00FF, strb 0x03, strb_taint 0x04 -> read taint 0x0000000000FF00FF.
REQ-034 Read of 0x0 with addr_taint 0x1 -> rdata_taint all ones; tainted-address write -> taint_addr_write_o=1 until reset.
REQ-035 Read of address Depth*8 -> err_o=1, rdata 0; write to that address leaves memory unchanged.
REQ-036 Assert rst_i one cycle after a read grant with ReadLatency=2 -> no rvalid after release; pointer back at port 0.
